// File: rtl/stepdown_nonoverlap_drv_if.sv
// stepdown_nonoverlap_drv_if: PWM command, enable, fault and zero-cross inputs plus gate-enable outputs.
interface stepdown_nonoverlap_drv_if;
  logic i;
  logic en;
  logic flt;
  logic zc;
  logic hs_on;
  logic ls_on;
  logic dt_act;
  logic flt_lat;
  modport master (output i, en, flt, zc, input hs_on, ls_on, dt_act, flt_lat);
  modport slave (input i, en, flt, zc, output hs_on, ls_on, dt_act, flt_lat);
endinterface

// File: rtl/stepdown_nonoverlap_drv.sv
// stepdown_nonoverlap_drv: non-overlapping HS/LS gate enables with dead time, minimum on-time and sticky fault.
// Define STEPDOWN_DIODE_EMU_EN to add diode emulation (LS_OFF on synchronized zero-cross).
module stepdown_nonoverlap_drv #(
  parameter int DT_CYC = 4,
  parameter int MIN_ON_CYC = 2,
  parameter int CW = 4
) (
  input logic CELCLK,
  input logic CELRSTN,
  input logic CELV,
  input logic CELG,
  input logic SUB,
  stepdown_nonoverlap_drv_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    HS,
    LS,
    DEAD_HL,
    DEAD_LH
`ifdef STEPDOWN_DIODE_EMU_EN
    , LS_OFF
`endif
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic i_meta, i_s;
  logic flt_lat_q, flt_lat_d;
  logic hs_q, ls_q, dt_q;
  logic on_ok, dt_done;
  logic unused_pins;
  always_ff @(posedge CELCLK or negedge CELRSTN)
    if (!CELRSTN) {i_meta, i_s} <= '0;
    else {i_meta, i_s} <= {bus.i, i_meta};
`ifdef STEPDOWN_DIODE_EMU_EN
  logic zc_meta, zc_s;
  always_ff @(posedge CELCLK or negedge CELRSTN)
    if (!CELRSTN) {zc_meta, zc_s} <= '0;
    else {zc_meta, zc_s} <= {bus.zc, zc_meta};
  assign unused_pins = ^{CELV, CELG, SUB};
`else
  assign unused_pins = ^{CELV, CELG, SUB, bus.zc};
`endif
  assign on_ok = cnt_q >= CW'(MIN_ON_CYC);
  assign dt_done = cnt_q == CW'(DT_CYC - 1);
  // fault outranks enable so a simultaneous fault and disable still latches
  always_comb begin
    state_d = state_q;
    flt_lat_d = flt_lat_q;
    if (bus.flt) begin
      state_d = IDLE;
      flt_lat_d = 1'b1;
    end else if (!bus.en) begin
      state_d = IDLE;
      flt_lat_d = 1'b0;
    end else
      case (state_q)
        IDLE: state_d = flt_lat_q ? IDLE : (i_s ? DEAD_LH : DEAD_HL);
        HS: state_d = (!i_s && on_ok) ? DEAD_HL : HS;
`ifdef STEPDOWN_DIODE_EMU_EN
        LS: state_d = !on_ok ? LS : i_s ? DEAD_LH : zc_s ? LS_OFF : LS;
        LS_OFF: state_d = i_s ? DEAD_LH : LS_OFF;
`else
        LS: state_d = (i_s && on_ok) ? DEAD_LH : LS;
`endif
        default: state_d = dt_done ? (i_s ? HS : LS) : state_q;
      endcase
    cnt_d = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end
  always_ff @(posedge CELCLK or negedge CELRSTN)
    if (!CELRSTN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      flt_lat_q <= 1'b0;
      hs_q <= 1'b0;
      ls_q <= 1'b0;
      dt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      flt_lat_q <= flt_lat_d;
      hs_q <= state_d == HS;
      ls_q <= state_d == LS;
      dt_q <= state_d == DEAD_HL || state_d == DEAD_LH;
    end
  assign bus.hs_on = hs_q;
  assign bus.ls_on = ls_q;
  assign bus.dt_act = dt_q;
  assign bus.flt_lat = flt_lat_q;
  always @(posedge CELCLK) assert (DT_CYC >= 1 && !(hs_q && ls_q));
endmodule
